// File: rtl/usrt_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usrt_tx_ctrl
// Description : USRT transmit sequencer. Takes host bytes into a one-byte
//               holding buffer and hands each byte to the external txparity
//               framer. It then captures the 11-bit frame from the framer and
//               shifts it out LSB-first on o_Tx at CLKS_PER_BIT clocks per bit.
// Ports       : i_Pclk      system clock (rising edge)
//               i_Rst_n     asynchronous active-low reset
//               i_Valid     host byte valid
//               i_Data      host byte
//               o_Ready     holding buffer empty (registered)
//               i_Parity    parity mode, 00 = no parity bit
//               o_Par_Data  byte presented to the framer
//               o_Par_Mode  parity mode presented to the framer
//               i_Frame     framer output {stop, parity, data[7:0], start}
//               o_Tx        serial line, idle high
//               o_Busy      high while loading or shifting a frame
//               o_Done      one-cycle pulse after the last stop-bit cycle
// Revision    : 1.0 - initial release
// ============================================================================
module usrt_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PAR_LATENCY  = 1
) (
    input  logic        i_Pclk,
    input  logic        i_Rst_n,
    input  logic        i_Valid,
    input  logic [7:0]  i_Data,
    output logic        o_Ready,
    input  logic [1:0]  i_Parity,
    output logic [7:0]  o_Par_Data,
    output logic [1:0]  o_Par_Mode,
    input  logic [10:0] i_Frame,
    output logic        o_Tx,
    output logic        o_Busy,
    output logic        o_Done
);

    localparam int                c_BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]        c_LOAD_MAX = 2'(PAR_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_e;

    state_e              state_q,    state_d;
    logic [7:0]          buf_q,      buf_d;
    logic                full_q,     full_d;
    logic                ready_q,    ready_d;
    logic [7:0]          par_data_q, par_data_d;
    logic [1:0]          par_mode_q, par_mode_d;
    logic [3:0]          nbits_q,    nbits_d;
    logic [10:0]         shreg_q,    shreg_d;
    logic [c_BAUD_W-1:0] baud_q,     baud_d;
    logic [3:0]          bit_q,      bit_d;
    logic [1:0]          load_q,     load_d;
    logic                done_q,     done_d;

    logic                w_accept;

    assign w_accept = i_Valid & ready_q;

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= S_IDLE;
            buf_q      <= 8'd0;
            full_q     <= 1'b0;
            ready_q    <= 1'b1;
            par_data_q <= 8'd0;
            par_mode_q <= 2'd0;
            nbits_q    <= 4'd0;
            shreg_q    <= '1;
            baud_q     <= '0;
            bit_q      <= 4'd0;
            load_q     <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
            ready_q    <= ready_d;
            par_data_q <= par_data_d;
            par_mode_q <= par_mode_d;
            nbits_q    <= nbits_d;
            shreg_q    <= shreg_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            load_q     <= load_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        full_d     = full_q;
        par_data_d = par_data_q;
        par_mode_d = par_mode_q;
        nbits_d    = nbits_q;
        shreg_d    = shreg_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        load_d     = load_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (full_q) begin
                    // The parity mode is sampled here, so later changes to
                    // i_Parity cannot reach the frame now in flight.
                    par_data_d = buf_q;
                    par_mode_d = i_Parity;
                    nbits_d    = (i_Parity == 2'b00) ? 4'd10 : 4'd11;
                    full_d     = 1'b0;
                    load_d     = 2'd0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_q == c_LOAD_MAX) begin
                    // Without parity the parity slot is dropped at capture,
                    // so the stop bit directly follows data bit 7.
                    if (nbits_q == 4'd11) begin
                        shreg_d = i_Frame;
                    end else begin
                        shreg_d = {1'b1, i_Frame[10], i_Frame[8:0]};
                    end
                    baud_d  = '0;
                    bit_d   = 4'd0;
                    state_d = S_SHIFT;
                end else begin
                    load_d = load_q + 2'd1;
                end
            end
            S_SHIFT: begin
                if (baud_q == c_BAUD_MAX) begin
                    baud_d = '0;
                    if (bit_q == (nbits_q - 4'd1)) begin
                        bit_d   = 4'd0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shreg_d = {1'b1, shreg_q[10:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new byte always wins over the buffer emptying on the same edge.
        if (w_accept) begin
            buf_d  = i_Data;
            full_d = 1'b1;
        end
    end

    assign ready_d    = ~full_d;

    assign o_Ready    = ready_q;
    assign o_Par_Data = par_data_q;
    assign o_Par_Mode = par_mode_q;
    assign o_Tx       = (state_q == S_SHIFT) ? shreg_q[0] : 1'b1;
    assign o_Busy     = (state_q != S_IDLE);
    assign o_Done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_usrt_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usrt_tx_ctrl
// Description : Self-checking bench for usrt_tx_ctrl. It contains a
//               behavioural txparity framer and a timeline reference model
//               that predicts o_Tx, o_Busy, o_Done and o_Ready for every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usrt_tx_ctrl;

    localparam int CPB  = 4;
    localparam int PL   = 1;
    localparam int MAXC = 8192;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  data  = 8'h00;
    logic [1:0]  par   = 2'b00;
    logic [10:0] frame;
    logic        ready, tx, busy, done;
    logic [7:0]  par_data;
    logic [1:0]  par_mode;

    int n_checks = 0;
    int n_errors = 0;

    usrt_tx_ctrl #(.CLKS_PER_BIT(CPB), .PAR_LATENCY(PL)) dut (
        .i_Pclk     (clk),
        .i_Rst_n    (rst_n),
        .i_Valid    (valid),
        .i_Data     (data),
        .o_Ready    (ready),
        .i_Parity   (par),
        .o_Par_Data (par_data),
        .o_Par_Mode (par_mode),
        .i_Frame    (frame),
        .o_Tx       (tx),
        .o_Busy     (busy),
        .o_Done     (done)
    );

    always #5 clk = ~clk;

    // Framer: 01 odd, 10 even, 11 mark, 00 none (bit unused).
    function automatic logic par_bit(input logic [7:0] d, input logic [1:0] m);
        case (m)
            2'b01:   return ~^d;
            2'b10:   return ^d;
            2'b11:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic [10:0] frame_q = '1;
    always @(posedge clk) frame_q <= {1'b1, par_bit(par_data, par_mode), par_data, 1'b0};
    assign frame = frame_q;

    // Reference model: a per-cycle timeline of the expected line behaviour.
    int         cyc = 0;
    bit         m_have = 1'b0;
    logic [7:0] m_buf = 8'h00;
    int         m_idle_from = 0;
    bit         e_tx   [MAXC];
    bit         e_busy [MAXC];
    bit         e_done [MAXC];

    function automatic void plan_frame(input int c, input logic [7:0] d, input logic [1:0] m);
        int nb, start, idx;
        bit v;
        nb    = (m == 2'b00) ? 10 : 11;
        start = c + PL + 2;
        for (int b = 0; b < nb; b++) begin
            if (b == 0)                  v = 1'b0;
            else if (b <= 8)             v = d[b-1];
            else if (b == 9 && nb == 11) v = par_bit(d, m);
            else                         v = 1'b1;
            for (int k = 0; k < CPB; k++) begin
                idx = start + b * CPB + k;
                if (idx < MAXC) e_tx[idx] = v;
            end
        end
        for (int i = c + 1; i < start + nb * CPB; i++)
            if (i < MAXC) e_busy[i] = 1'b1;
        if (start + nb * CPB < MAXC) e_done[start + nb * CPB] = 1'b1;
        m_idle_from = start + nb * CPB;
    endfunction

    always @(posedge clk) begin
        bit rdy;
        if (!rst_n) begin
            m_have      = 1'b0;
            m_idle_from = 0;
            for (int i = 0; i < MAXC; i++) begin
                e_tx[i]   = 1'b1;
                e_busy[i] = 1'b0;
                e_done[i] = 1'b0;
            end
        end else begin
            rdy = !m_have;
            if (m_have && cyc >= m_idle_from) begin
                plan_frame(cyc, m_buf, par);
                m_have = 1'b0;
            end
            if (valid && rdy) begin
                m_buf  = data;
                m_have = 1'b1;
            end
        end
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (cyc < MAXC) begin
            chk("tx",    {31'd0, tx},    {31'd0, e_tx[cyc]});
            chk("busy",  {31'd0, busy},  {31'd0, e_busy[cyc]});
            chk("done",  {31'd0, done},  {31'd0, e_done[cyc]});
            chk("ready", {31'd0, ready}, {31'd0, !m_have});
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] m);
        int g = 0;
        while (m_have && g < 2000) begin
            tick();
            g++;
        end
        if (m_have) begin
            n_checks++;
            n_errors++;
            $error("FAIL send_wait: observed=buffer_full expected=buffer_empty cycle=%0d", cyc);
        end
        data  = d;
        par   = m;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((m_have || cyc < m_idle_from) && g < 3000) begin
            tick();
            g++;
        end
        if (m_have || cyc < m_idle_from) begin
            n_checks++;
            n_errors++;
            $error("FAIL idle_wait: observed=busy expected=idle cycle=%0d", cyc);
        end
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx",       {31'd0, tx},    32'd1);
        chk("rst_ready",    {31'd0, ready}, 32'd1);
        chk("rst_busy",     {31'd0, busy},  32'd0);
        chk("rst_done",     {31'd0, done},  32'd0);
        chk("rst_par_data", {24'd0, par_data}, 32'd0);
        chk("rst_par_mode", {30'd0, par_mode}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle line after reset.
        repeat (20) tick();

        // Parity frame, then a no-parity frame.
        send(8'h03, 2'b01);
        wait_idle();
        send(8'h07, 2'b00);
        wait_idle();

        // Back-to-back: second byte offered while the first is shifting.
        send(8'h03, 2'b10);
        repeat (10) tick();
        send(8'h07, 2'b10);
        wait_idle();

        // Parity mode changed mid-frame only affects the next frame.
        send(8'h55, 2'b01);
        repeat (12) tick();
        par = 2'b00;
        repeat (8) tick();
        send(8'hA5, 2'b00);
        wait_idle();

        // Reset in the middle of data bit 0 of an all-zero byte.
        send(8'h00, 2'b11);
        repeat (9) tick();
        chk("pre_rst_tx", {31'd0, tx}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_tx",   {31'd0, tx},    32'd1);
        chk("midrst_busy", {31'd0, busy},  32'd0);
        chk("midrst_done", {31'd0, done},  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) tick();

        // Randomized traffic with random gaps, modes and mid-frame mode churn.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 60)) tick();
            send(8'($urandom), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 20)) tick();
            par = 2'($urandom_range(0, 3));
        end
        wait_idle();
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
